// File: rtl/sum_sequencer.sv
// sum_sequencer: round-robin controller that steps a shared load/add/display
// datapath through LOAD, SHOW_A, SHOW_B, SHOW_SUM and captures the sum.
module sum_sequencer #(
  parameter int WIDTH = 8,
  parameter int DWELL = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req0,
  input  logic               i_req1,
  input  logic [WIDTH-1:0]   i_a0,
  input  logic [WIDTH-1:0]   i_b0,
  input  logic [WIDTH-1:0]   i_a1,
  input  logic [WIDTH-1:0]   i_b1,
  input  logic               i_hold,
  input  logic [2*WIDTH-1:0] i_sum_in,
  output logic [WIDTH-1:0]   o_op_a,
  output logic [WIDTH-1:0]   o_op_b,
  output logic               o_ld,
  output logic [1:0]         o_sel,
  output logic [1:0]         o_grant,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_done_id,
  output logic [2*WIDTH-1:0] o_result
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHOW_A, S_SHOW_B, S_SHOW_SUM, S_DONE
  } state_t;

  localparam logic [7:0] LP_DWELL_LAST = 8'(DWELL - 1);

  state_t             r_state;
  logic [7:0]         r_dwell;
  logic               r_last;
  logic               r_ld;
  logic [1:0]         r_sel;
  logic [1:0]         r_grant;
  logic               r_busy;
  logic               r_done;
  logic               r_done_id;
  logic [2*WIDTH-1:0] r_result;

  logic w_any_req;
  logic w_winner;
  logic w_dwell_end;

  // On a tie the requester that was not served last wins; a lone request wins outright.
  assign w_any_req   = i_req0 | i_req1;
  assign w_winner    = (i_req0 & i_req1) ? ~r_last : ~i_req0;
  assign w_dwell_end = (r_dwell == LP_DWELL_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_dwell   <= '0;
      r_last    <= 1'b1;
      r_ld      <= 1'b0;
      r_sel     <= 2'b00;
      r_grant   <= 2'b00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state <= S_LOAD;
            r_grant <= w_winner ? 2'b10 : 2'b01;
            r_last  <= w_winner;
            r_ld    <= 1'b1;
            r_busy  <= 1'b1;
            r_sel   <= 2'b00;
          end
        end
        S_LOAD: begin
          r_state <= S_SHOW_A;
          r_ld    <= 1'b0;
          r_sel   <= 2'b01;
          r_dwell <= '0;
        end
        S_SHOW_A: begin
          if (!i_hold) begin
            if (w_dwell_end) begin
              r_state <= S_SHOW_B;
              r_sel   <= 2'b10;
              r_dwell <= '0;
            end else begin
              r_dwell <= r_dwell + 8'd1;
            end
          end
        end
        S_SHOW_B: begin
          if (!i_hold) begin
            if (w_dwell_end) begin
              r_state <= S_SHOW_SUM;
              r_sel   <= 2'b11;
              r_dwell <= '0;
            end else begin
              r_dwell <= r_dwell + 8'd1;
            end
          end
        end
        // The sum is captured on the same edge that leaves SHOW_SUM.
        S_SHOW_SUM: begin
          if (!i_hold) begin
            if (w_dwell_end) begin
              r_state   <= S_DONE;
              r_sel     <= 2'b00;
              r_dwell   <= '0;
              r_result  <= i_sum_in;
              r_done    <= 1'b1;
              r_done_id <= r_grant[1];
            end else begin
              r_dwell <= r_dwell + 8'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ld    <= 1'b0;
          r_sel   <= 2'b00;
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_op_a    = r_grant[0] ? i_a0 : (r_grant[1] ? i_a1 : '0);
  assign o_op_b    = r_grant[0] ? i_b0 : (r_grant[1] ? i_b1 : '0);
  assign o_ld      = r_ld;
  assign o_sel     = r_sel;
  assign o_grant   = r_grant;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_done_id = r_done_id;
  assign o_result  = r_result;

endmodule

// File: tb/tb_sum_sequencer.sv
// Bench for sum_sequencer: two instances (DWELL=1 and DWELL=3) with a small
// datapath model, checked cycle by cycle against a transaction-level model.
module tb_sum_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rq0, rq1;
  logic [7:0] a0, b0, a1, b1;
  logic       hold;

  logic [7:0]  opa[2], opb[2];
  logic        ld[2], busy[2], done[2], doneid[2];
  logic [1:0]  sel[2], grant[2];
  logic [15:0] result[2], sumv[2];

  int checks = 0;
  int failures = 0;
  int du = 0;
  bit lastM[2];

  always #5 clk = ~clk;

  sum_sequencer #(.WIDTH(8), .DWELL(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req0(rq0[0]), .i_req1(rq1[0]),
    .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1), .i_hold(hold), .i_sum_in(sumv[0]),
    .o_op_a(opa[0]), .o_op_b(opb[0]), .o_ld(ld[0]), .o_sel(sel[0]), .o_grant(grant[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_done_id(doneid[0]), .o_result(result[0])
  );

  sum_sequencer #(.WIDTH(8), .DWELL(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req0(rq0[1]), .i_req1(rq1[1]),
    .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1), .i_hold(hold), .i_sum_in(sumv[1]),
    .o_op_a(opa[1]), .o_op_b(opb[1]), .o_ld(ld[1]), .o_sel(sel[1]), .o_grant(grant[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_done_id(doneid[1]), .o_result(result[1])
  );

  // Shared datapath stand-in: operand registers loaded on Ld, plain adder.
  for (genvar g = 0; g < 2; g++) begin : g_dp
    logic [7:0] raQ, rbQ;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        raQ <= '0;
        rbQ <= '0;
      end else if (ld[g]) begin
        raQ <= opa[g];
        rbQ <= opb[g];
      end
    end
    assign sumv[g] = 16'(raQ) + 16'(rbQ);
  end

  // One transaction from the IDLE cycle to the following IDLE cycle.
  task automatic do_txn(input bit r0, input bit r1, input bit keep,
                        input int holdAt, input int holdLen, input bit idleHold);
    int d;
    bit winner;
    logic [1:0] eg;
    logic [7:0] ea, eb;
    logic [15:0] expSum;
    logic [1:0] selQ[$];
    d = (du == 1) ? 3 : 1;
    if (r0 && r1) winner = ~lastM[du];
    else winner = r1;
    lastM[du] = winner;
    eg = winner ? 2'b10 : 2'b01;
    ea = winner ? a1 : a0;
    eb = winner ? b1 : b0;
    expSum = 16'(ea) + 16'(eb);
    for (int i = 0; i < d; i++) selQ.push_back(2'b01);
    for (int i = 0; i < d; i++) selQ.push_back(2'b10);
    for (int i = 0; i < d; i++) selQ.push_back(2'b11);
    for (int h = 0; h < holdLen; h++) selQ.insert(holdAt, selQ[holdAt]);

    rq0[du] = r0;
    rq1[du] = r1;
    hold = idleHold;
    @(posedge clk); #1;
    hold = 1'b0;
    if (!keep) begin
      rq0[du] = 1'b0;
      rq1[du] = 1'b0;
    end
    checks++;
    if ({ld[du], sel[du], grant[du], busy[du], done[du], opa[du], opb[du]} !==
        {1'b1, 2'b00, eg, 1'b1, 1'b0, ea, eb}) begin
      failures++;
      $display("[TB] FAIL load: got %h expected %h",
               {ld[du], sel[du], grant[du], busy[du], done[du], opa[du], opb[du]},
               {1'b1, 2'b00, eg, 1'b1, 1'b0, ea, eb});
    end
    for (int s = 0; s < selQ.size(); s++) begin
      @(posedge clk); #1;
      hold = (s >= holdAt) && (s < holdAt + holdLen);
      checks++;
      if ({ld[du], sel[du], grant[du], busy[du], done[du]} !== {1'b0, selQ[s], eg, 1'b1, 1'b0}) begin
        failures++;
        $display("[TB] FAIL show[%0d]: got %h expected %h", s,
                 {ld[du], sel[du], grant[du], busy[du], done[du]}, {1'b0, selQ[s], eg, 1'b1, 1'b0});
      end
    end
    hold = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ld[du], sel[du], grant[du], busy[du], done[du], doneid[du]} !==
        {1'b0, 2'b00, eg, 1'b1, 1'b1, winner}) begin
      failures++;
      $display("[TB] FAIL done: got %h expected %h",
               {ld[du], sel[du], grant[du], busy[du], done[du], doneid[du]},
               {1'b0, 2'b00, eg, 1'b1, 1'b1, winner});
    end
    checks++;
    if (result[du] !== expSum) begin
      failures++;
      $display("[TB] FAIL result: got %h expected %h", result[du], expSum);
    end
    @(posedge clk); #1;
    checks++;
    if ({ld[du], sel[du], grant[du], busy[du], done[du], opa[du], result[du]} !==
        {1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, expSum}) begin
      failures++;
      $display("[TB] FAIL idle: got %h expected %h",
               {ld[du], sel[du], grant[du], busy[du], done[du], opa[du], result[du]},
               {1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, expSum});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rq0 = '0;
    rq1 = '0;
    hold = 1'b0;
    a0 = 8'h5A; b0 = 8'hA5; a1 = 8'h3C; b1 = 8'hC3;
    lastM[0] = 1'b1;
    lastM[1] = 1'b1;
    #3;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({opa[i], opb[i], ld[i], sel[i], grant[i], busy[i], done[i], doneid[i], result[i]} !== 40'h0) begin
        failures++;
        $display("[TB] FAIL reset[%0d]: got %h expected 0", i,
                 {opa[i], opb[i], ld[i], sel[i], grant[i], busy[i], done[i], doneid[i], result[i]});
      end
    end
    #7 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    du = 0;
    a0 = 8'h12; b0 = 8'h34;
    do_txn(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    du = 0;
    a0 = 8'($urandom); b0 = 8'($urandom);
    a1 = 8'hFF; b1 = 8'h01;
    for (int i = 0; i < 4; i++) do_txn(1'b1, 1'b1, (i < 3), 0, 0, 1'b0);
  endtask

  task automatic test_dwell3();
    du = 1;
    a1 = 8'($urandom); b1 = 8'($urandom);
    do_txn(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    a0 = 8'($urandom); b0 = 8'($urandom);
    do_txn(1'b1, 1'b0, 1'b0, 4, 2, 1'b0);
    du = 0;
  endtask

  task automatic test_hold();
    du = 0;
    a0 = 8'($urandom); b0 = 8'($urandom);
    do_txn(1'b1, 1'b0, 1'b0, 1, 4, 1'b0);
    do_txn(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      int v, d;
      du = int'($urandom_range(0, 1));
      d = (du == 1) ? 3 : 1;
      v = int'($urandom_range(1, 3));
      a0 = 8'($urandom); b0 = 8'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom);
      do_txn(v[0], v[1], 1'b0, int'($urandom_range(0, 3 * d - 1)), int'($urandom_range(0, 3)), 1'b0);
    end
    du = 0;
  endtask

  task automatic test_reset_mid();
    du = 0;
    a0 = 8'h77; b0 = 8'h11; a1 = 8'h22; b1 = 8'h33;
    rq0[0] = 1'b1;
    @(posedge clk); #1;
    rq0[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (sel[0] !== 2'b11) begin
      failures++;
      $display("[TB] FAIL pre_abort_sel: got %h expected 3", sel[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({opa[0], opb[0], ld[0], sel[0], grant[0], busy[0], done[0], doneid[0], result[0]} !== 40'h0) begin
      failures++;
      $display("[TB] FAIL abort: got %h expected 0",
               {opa[0], opb[0], ld[0], sel[0], grant[0], busy[0], done[0], doneid[0], result[0]});
    end
    #3 rst_n = 1'b1;
    lastM[0] = 1'b1;
    lastM[1] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy[0], done[0], result[0]} !== 18'h0) begin
      failures++;
      $display("[TB] FAIL post_abort: got %h expected 0", {busy[0], done[0], result[0]});
    end
    do_txn(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_dwell3();
    test_hold();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
